// File: rtl/regs_arb_pkg.sv
// Shared types and constants for the register-file arbiter.
// The arbiter state enum is also used by the bench to decode the exposed state.
package regs_arb_pkg;

    typedef enum logic [1:0] {
        CORE_PRI   = 2'd0,
        DBG_FORCED = 2'd1,
        DBG_LOCKED = 2'd2
    } arb_state_t;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

endpackage

// File: rtl/regs_arbiter.sv
// Arbitrates the single-write, dual-read register file between the core pipeline
// and the debug port, with starvation forcing and an exclusive debug lock.
module regs_arbiter
    import regs_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [REG_ADDR_W-1:0] core_addr_a,
    input  logic [REG_ADDR_W-1:0] core_addr_b,
    input  logic [N-1:0]          core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [N-1:0]          core_rdata_a,
    output logic [N-1:0]          core_rdata_b,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [N-1:0]          dbg_wdata,
    input  logic                  dbg_lock,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [N-1:0]          dbg_rdata,
    output logic                  dbg_locked,

    output logic [REG_ADDR_W-1:0] rf_r_addr1,
    output logic [REG_ADDR_W-1:0] rf_r_addr2,
    output logic                  rf_w_en,
    output logic [N-1:0]          rf_w_data,
    input  logic [N-1:0]          rf_reg_data1,
    input  logic [N-1:0]          rf_reg_data2,

    output arb_state_t            arb_state,
    output logic [3:0]            wait_count
);

    localparam int WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;

    // Handshake: a requester holds req and its fields stable until it sees gnt in
    // the same cycle; gnt is combinational and means the access happens at this edge.
    // Read data follows one cycle later with rvalid, never for write grants.
    always_comb begin
        core_gnt   = 1'b0;
        dbg_gnt    = 1'b0;
        state_next = state;
        case (state)
            CORE_PRI: begin
                core_gnt = core_req;
                dbg_gnt  = dbg_req & ~core_req;
                if (dbg_lock) begin
                    state_next = DBG_LOCKED;
                end else if (dbg_req && !dbg_gnt && (wait_cnt == WAIT_LAST)) begin
                    state_next = DBG_FORCED;
                end
            end
            DBG_FORCED: begin
                dbg_gnt = dbg_req;
                if (dbg_lock) begin
                    state_next = DBG_LOCKED;
                end else if (dbg_gnt || !dbg_req) begin
                    state_next = CORE_PRI;
                end
            end
            DBG_LOCKED: begin
                dbg_gnt = dbg_req;
                if (!dbg_lock) begin
                    state_next = CORE_PRI;
                end
            end
            default: begin
                state_next = CORE_PRI;
            end
        endcase
    end

    // Starvation counter: counts consecutive denied debug cycles, saturating.
    always_comb begin
        wait_next = wait_cnt;
        if (!dbg_req || dbg_gnt || (state == DBG_LOCKED && !dbg_lock)) begin
            wait_next = '0;
        end else if (wait_cnt < WAIT_MAX) begin
            wait_next = wait_cnt + 1'b1;
        end
    end

    // Only the granted requester drives the register-file pins; idle pins are zero.
    always_comb begin
        rf_r_addr1 = '0;
        rf_r_addr2 = '0;
        rf_w_en    = 1'b0;
        rf_w_data  = '0;
        if (core_gnt) begin
            rf_r_addr1 = core_addr_a;
            rf_r_addr2 = core_addr_b;
            rf_w_en    = core_we;
            rf_w_data  = core_wdata;
        end else if (dbg_gnt) begin
            rf_r_addr2 = dbg_addr;
            rf_w_en    = dbg_we;
            rf_w_data  = dbg_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CORE_PRI;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Read data is captured only on read grants so rdata holds while rvalid is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_rvalid  <= 1'b0;
            core_rdata_a <= '0;
            core_rdata_b <= '0;
            dbg_rvalid   <= 1'b0;
            dbg_rdata    <= '0;
        end else begin
            core_rvalid <= core_gnt & ~core_we;
            dbg_rvalid  <= dbg_gnt & ~dbg_we;
            if (core_gnt && !core_we) begin
                core_rdata_a <= rf_reg_data1;
                core_rdata_b <= rf_reg_data2;
            end
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= rf_reg_data2;
            end
        end
    end

    assign dbg_locked = (state == DBG_LOCKED);
    assign arb_state  = state;
    assign wait_count = wait_cnt;

endmodule

// File: tb/tb_regs_arbiter.sv
// Directed bench for regs_arbiter with a behavioural register file and a
// read-data scoreboard fed by the stimulus and drained by a monitor.
module tb_regs_arbiter;
    import regs_arb_pkg::*;

    localparam int N = 8;

    logic                  clock;
    logic                  reset;
    logic                  core_req, core_we;
    logic [REG_ADDR_W-1:0] core_addr_a, core_addr_b;
    logic [N-1:0]          core_wdata;
    logic                  core_gnt, core_rvalid;
    logic [N-1:0]          core_rdata_a, core_rdata_b;
    logic                  dbg_req, dbg_we, dbg_lock;
    logic [REG_ADDR_W-1:0] dbg_addr;
    logic [N-1:0]          dbg_wdata;
    logic                  dbg_gnt, dbg_rvalid, dbg_locked;
    logic [N-1:0]          dbg_rdata;
    logic [REG_ADDR_W-1:0] rf_r_addr1, rf_r_addr2;
    logic                  rf_w_en;
    logic [N-1:0]          rf_w_data, rf_reg_data1, rf_reg_data2;
    arb_state_t            arb_state;
    logic [3:0]            wait_count;

    int passed = 0;
    int total  = 0;

    logic [2*N-1:0] core_exp_q[$];
    logic [N-1:0]   dbg_exp_q[$];

    regs_arbiter #(.N(N), .MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_we(core_we),
        .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata_a(core_rdata_a), .core_rdata_b(core_rdata_b),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_locked(dbg_locked),
        .rf_r_addr1(rf_r_addr1), .rf_r_addr2(rf_r_addr2),
        .rf_w_en(rf_w_en), .rf_w_data(rf_w_data),
        .rf_reg_data1(rf_reg_data1), .rf_reg_data2(rf_reg_data2),
        .arb_state(arb_state), .wait_count(wait_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural register file: r0 reads as zero, preset r3/r5 on reset
    logic [N-1:0] rf_mem [32];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            rf_mem[3] <= 8'h11;
            rf_mem[5] <= 8'h22;
        end else if (rf_w_en && rf_r_addr2 != 0) begin
            rf_mem[rf_r_addr2] <= rf_w_data;
        end
    end
    assign rf_reg_data1 = (rf_r_addr1 == 0) ? '0 : rf_mem[rf_r_addr1];
    assign rf_reg_data2 = (rf_r_addr2 == 0) ? '0 : rf_mem[rf_r_addr2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        core_req = 0; core_we = 0; core_addr_a = '0; core_addr_b = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
    endtask

    task automatic drive_core(input logic we, input logic [4:0] a, input logic [4:0] b,
                              input logic [N-1:0] wd);
        core_req = 1; core_we = we; core_addr_a = a; core_addr_b = b; core_wdata = wd;
    endtask

    task automatic drive_dbg(input logic we, input logic [4:0] addr, input logic [N-1:0] wd);
        dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        if (core_rvalid === 1'b1) begin
            if (core_exp_q.size() == 0) begin
                check("core_rvalid_unexpected", 32'(core_rvalid), 32'd0);
            end else begin
                logic [2*N-1:0] e;
                e = core_exp_q.pop_front();
                check("core_rdata_a", 32'(core_rdata_a), 32'(e[2*N-1:N]));
                check("core_rdata_b", 32'(core_rdata_b), 32'(e[N-1:0]));
            end
        end
        if (dbg_rvalid === 1'b1) begin
            if (dbg_exp_q.size() == 0) begin
                check("dbg_rvalid_unexpected", 32'(dbg_rvalid), 32'd0);
            end else begin
                logic [N-1:0] d;
                d = dbg_exp_q.pop_front();
                check("dbg_rdata", 32'(dbg_rdata), 32'(d));
            end
        end
    end

    initial begin
        reset = 1;
        drive_idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_state", 32'(arb_state), 32'(CORE_PRI));
        check("rst_wait", 32'(wait_count), 32'd0);
        check("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_core_rdata_a", 32'(core_rdata_a), 32'd0);
        check("rst_dbg_locked", 32'(dbg_locked), 32'd0);
        tick();
        reset = 0;

        // idle cycle: no grants, all pins zero
        @(negedge clock);
        check("idle_core_gnt", 32'(core_gnt), 32'd0);
        check("idle_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("idle_rf_r_addr1", 32'(rf_r_addr1), 32'd0);
        check("idle_rf_r_addr2", 32'(rf_r_addr2), 32'd0);
        check("idle_rf_w_en", 32'(rf_w_en), 32'd0);
        check("idle_rf_w_data", 32'(rf_w_data), 32'd0);

        // core read r3/r5
        tick();
        drive_core(0, 5'd3, 5'd5, 8'h00);
        @(negedge clock);
        check("rd_core_gnt", 32'(core_gnt), 32'd1);
        check("rd_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rd_rf_r_addr1", 32'(rf_r_addr1), 32'd3);
        check("rd_rf_r_addr2", 32'(rf_r_addr2), 32'd5);
        core_exp_q.push_back({8'h11, 8'h22});

        // core write A5 to r7, then debug read of r7
        tick();
        drive_core(1, 5'd0, 5'd7, 8'hA5);
        @(negedge clock);
        check("wr_core_gnt", 32'(core_gnt), 32'd1);
        check("wr_rf_w_en", 32'(rf_w_en), 32'd1);
        check("wr_rf_r_addr2", 32'(rf_r_addr2), 32'd7);
        check("wr_rf_w_data", 32'(rf_w_data), 32'hA5);
        tick();
        drive_idle();
        drive_dbg(0, 5'd7, 8'h00);
        @(negedge clock);
        check("dbgrd_dbg_gnt", 32'(dbg_gnt), 32'd1);
        check("dbgrd_rf_r_addr1", 32'(rf_r_addr1), 32'd0);
        check("dbgrd_rf_r_addr2", 32'(rf_r_addr2), 32'd7);
        dbg_exp_q.push_back(8'hA5);
        tick();
        drive_idle();

        // starvation: core writes r0 continuously, debug reads r3
        tick();
        drive_core(1, 5'd0, 5'd0, 8'h55);
        drive_dbg(0, 5'd3, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("starve_core_gnt", 32'(core_gnt), 32'd1);
            check("starve_dbg_gnt", 32'(dbg_gnt), 32'd0);
            check("starve_wait", 32'(wait_count), 32'(i));
            tick();
        end
        @(negedge clock);
        check("forced_dbg_gnt", 32'(dbg_gnt), 32'd1);
        check("forced_core_gnt", 32'(core_gnt), 32'd0);
        check("forced_state", 32'(arb_state), 32'(DBG_FORCED));
        check("forced_rf_r_addr2", 32'(rf_r_addr2), 32'd3);
        dbg_exp_q.push_back(8'h11);
        tick();
        dbg_req = 0;
        @(negedge clock);
        check("regain_core_gnt", 32'(core_gnt), 32'd1);
        check("regain_state", 32'(arb_state), 32'(CORE_PRI));
        check("regain_wait", 32'(wait_count), 32'd0);

        // lock while the core is requesting
        tick();
        dbg_lock = 1;
        @(negedge clock);
        check("lockrise_core_gnt", 32'(core_gnt), 32'd1);
        check("lockrise_dbg_locked", 32'(dbg_locked), 32'd0);
        tick();
        drive_dbg(1, 5'd1, 8'h3C);
        @(negedge clock);
        check("locked_flag", 32'(dbg_locked), 32'd1);
        check("locked_core_gnt", 32'(core_gnt), 32'd0);
        check("locked_dbg_gnt", 32'(dbg_gnt), 32'd1);
        check("locked_rf_w_en", 32'(rf_w_en), 32'd1);
        check("locked_rf_r_addr2", 32'(rf_r_addr2), 32'd1);
        check("locked_rf_w_data", 32'(rf_w_data), 32'h3C);
        tick();
        drive_idle();
        drive_core(0, 5'd1, 5'd1, 8'h00);
        @(negedge clock);
        check("unlock_core_gnt", 32'(core_gnt), 32'd0);
        check("unlock_flag", 32'(dbg_locked), 32'd1);
        tick();
        @(negedge clock);
        check("post_lock_core_gnt", 32'(core_gnt), 32'd1);
        check("post_lock_flag", 32'(dbg_locked), 32'd0);
        check("post_lock_rf_r_addr1", 32'(rf_r_addr1), 32'd1);
        core_exp_q.push_back({8'h3C, 8'h3C});

        // reset while forced with a core read result pending
        tick();
        drive_idle();
        drive_core(0, 5'd3, 5'd5, 8'h00);
        drive_dbg(0, 5'd5, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rst_starve_core_gnt", 32'(core_gnt), 32'd1);
            check("rst_starve_wait", 32'(wait_count), 32'(i));
            core_exp_q.push_back({8'h11, 8'h22});
            tick();
        end
        reset = 1;
        @(negedge clock);
        check("prerst_state", 32'(arb_state), 32'(DBG_FORCED));
        check("prerst_core_rvalid", 32'(core_rvalid), 32'd1);
        tick();
        drive_idle();
        @(negedge clock);
        check("postrst_state", 32'(arb_state), 32'(CORE_PRI));
        check("postrst_core_rvalid", 32'(core_rvalid), 32'd0);
        check("postrst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("postrst_core_rdata_a", 32'(core_rdata_a), 32'd0);
        check("postrst_core_rdata_b", 32'(core_rdata_b), 32'd0);
        check("postrst_dbg_rdata", 32'(dbg_rdata), 32'd0);
        check("postrst_dbg_locked", 32'(dbg_locked), 32'd0);
        check("postrst_wait", 32'(wait_count), 32'd0);
        tick();
        reset = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);

        // final report
        check("core_q_drained", 32'(core_exp_q.size()), 32'd0);
        check("dbg_q_drained", 32'(dbg_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
